tx_chan_arbiter: RTL and testbench

- Shares the single TX chain among NUM_CHAN channel FIFO readers.
- Grants the chain to one channel at a time and holds the grant for a whole burst (reader burst flag).
- Round-robin between bursts.
- Gates each reader's pkt_waiting and tx_strobe so only the granted reader advances; muxes the granted reader's samples to the TX chain.

---
 rtl/tx_arb_pkg.sv | 32 +++
 rtl/tx_rr_pick.sv | 35 +++
 rtl/tx_chan_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tx_chan_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared definitions for the TX channel arbiter.
//   - 2-bit state encoding (IDLE, ACTIVE, HOLD, RELEASE)
//   - default channel count and sample width
//   - oh_index(): one-hot to binary index helper (up to 8 channels)
package tx_arb_pkg;

  localparam int DEF_NUM_CHAN = 2;
  localparam int SAMPLE_W     = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ACTIVE  = ST_ACTIVE,
    HOLD    = ST_HOLD,
    RELEASE = ST_RELEASE
  } arb_state_t;

  // Binary index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [2:0] oh_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// tx_rr_pick: combinational round-robin picker.
// Searches req upward from ptr (ptr itself first), wrapping at NUM_CHAN,
// and returns the first requester as a one-hot grant.
//   req   in  NUM_CHAN  request vector
//   ptr   in  PW        search start index (0..NUM_CHAN-1)
//   grant out NUM_CHAN  one-hot winner (0 when no request)
//   valid out 1         any request present
module tx_rr_pick import tx_arb_pkg::*; #(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int PW       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [PW-1:0]       ptr,
  output logic [NUM_CHAN-1:0] grant,
  output logic                valid
);

  // One extra bit so ptr+i never overflows before the wrap subtraction.
  logic [PW:0] pos;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_CHAN)) pos = pos - (PW+1)'(NUM_CHAN);
      if (!valid && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        valid              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_chan_arbiter.sv
// tx_chan_arbiter: shares one TX chain among NUM_CHAN channel FIFO readers.
// A channel owns the chain for a whole burst; ownership rotates round-robin
// between bursts. An open burst waiting for its next packet is held for at
// most HOLD_TIMEOUT cycles before being forcibly released.
//
// Build option: define TX_ARB_PRIORITY_EN to make channel 0 win every
// arbitration it requests in (an open burst is still never pre-empted).
//
// Ports:
//   tx_clock          in   clock
//   reset             in   synchronous, active-high
//   tx_strobe         in   TX chain sample request
//   chan_pkt_waiting  in   [NUM_CHAN] per-channel packet ready
//   chan_burst        in   [NUM_CHAN] per-reader burst-open flag
//   chan_skip         in   [NUM_CHAN] per-reader end-of-packet pulse
//   chan_tx_empty     in   [NUM_CHAN] per-reader empty flag
//   chan_tx_i/q       in   [16*NUM_CHAN] packed samples, ch k at [16k+15:16k]
//   rd_pkt_waiting    out  [NUM_CHAN] pkt_waiting gated by grant
//   rd_strobe         out  [NUM_CHAN] tx_strobe gated by grant
//   tx_i/tx_q         out  [16] registered samples of the granted channel
//   tx_empty          out  registered empty of the granted channel (1 if none)
//   grant             out  [NUM_CHAN] one-hot owner
//   timeout_pulse     out  one-cycle pulse on forced release
module tx_chan_arbiter import tx_arb_pkg::*; #(
  parameter int NUM_CHAN     = DEF_NUM_CHAN,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int CW           = 11
) (
  input  logic                         tx_clock,
  input  logic                         reset,
  input  logic                         tx_strobe,
  input  logic [NUM_CHAN-1:0]          chan_pkt_waiting,
  input  logic [NUM_CHAN-1:0]          chan_burst,
  input  logic [NUM_CHAN-1:0]          chan_skip,
  input  logic [NUM_CHAN-1:0]          chan_tx_empty,
  input  logic [SAMPLE_W*NUM_CHAN-1:0] chan_tx_i,
  input  logic [SAMPLE_W*NUM_CHAN-1:0] chan_tx_q,
  output logic [NUM_CHAN-1:0]          rd_pkt_waiting,
  output logic [NUM_CHAN-1:0]          rd_strobe,
  output logic [SAMPLE_W-1:0]          tx_i,
  output logic [SAMPLE_W-1:0]          tx_q,
  output logic                         tx_empty,
  output logic [NUM_CHAN-1:0]          grant,
  output logic                         timeout_pulse
);

  localparam int PW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  arb_state_t          state;
  logic [PW-1:0]       rr_ptr;
  logic [CW-1:0]       hold_cnt;

  logic [NUM_CHAN-1:0] rr_grant;
  logic                rr_valid;
  logic [NUM_CHAN-1:0] pick_grant;
  logic                pick_valid;
  logic [PW-1:0]       g_idx;
  logic                own_skip, own_burst, own_req;
  logic [SAMPLE_W-1:0] mux_i, mux_q;
  logic                mux_empty;

  tx_rr_pick #(.NUM_CHAN(NUM_CHAN), .PW(PW)) u_rr (
    .req   (chan_pkt_waiting),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .valid (rr_valid)
  );

`ifdef TX_ARB_PRIORITY_EN
  // A second picker that only sees channel 0 overrides the rotation.
  logic [NUM_CHAN-1:0] prio_grant;
  logic                prio_valid;

  tx_rr_pick #(.NUM_CHAN(NUM_CHAN), .PW(PW)) u_prio (
    .req   ({{(NUM_CHAN-1){1'b0}}, chan_pkt_waiting[0]}),
    .ptr   ('0),
    .grant (prio_grant),
    .valid (prio_valid)
  );

  assign pick_grant = prio_valid ? prio_grant : rr_grant;
  assign pick_valid = rr_valid;
`else
  assign pick_grant = rr_grant;
  assign pick_valid = rr_valid;
`endif

  assign rd_pkt_waiting = chan_pkt_waiting & grant;
  assign rd_strobe      = {NUM_CHAN{tx_strobe}} & grant;

  // Only the owner's flags matter; other channels' skips are ignored.
  assign own_skip  = |(chan_skip & grant);
  assign own_burst = |(chan_burst & grant);
  assign own_req   = |(chan_pkt_waiting & grant);
  assign g_idx     = PW'(oh_index(8'(grant)));

  always_comb begin
    mux_i     = '0;
    mux_q     = '0;
    mux_empty = 1'b1;
    for (int k = 0; k < NUM_CHAN; k++) begin
      if (grant[k]) begin
        mux_i     = chan_tx_i[SAMPLE_W*k +: SAMPLE_W];
        mux_q     = chan_tx_q[SAMPLE_W*k +: SAMPLE_W];
        mux_empty = chan_tx_empty[k];
      end
    end
  end

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
      tx_i          <= '0;
      tx_q          <= '0;
      tx_empty      <= 1'b1;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      tx_i          <= mux_i;
      tx_q          <= mux_q;
      tx_empty      <= mux_empty;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick_grant;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (own_skip) begin
            if (own_burst) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              state <= RELEASE;
            end
          end
        end
        HOLD: begin
          // A request arriving on the timeout cycle keeps the burst alive.
          if (own_req) begin
            hold_cnt <= '0;
            state    <= ACTIVE;
          end else if (hold_cnt == CW'(HOLD_TIMEOUT-1)) begin
            timeout_pulse <= 1'b1;
            state         <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        RELEASE: begin
          grant  <= '0;
          rr_ptr <= (g_idx == PW'(NUM_CHAN-1)) ? '0 : g_idx + PW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_chan_arbiter.sv
// tb_tx_chan_arbiter: directed bench for tx_chan_arbiter (2 channels,
// short hold timeout). A vector table covers basic round-robin, gating and
// the data mux; hand-written sequences cover bursts, timeout and reset.
module tb_tx_chan_arbiter;

  localparam int N  = 2;
  localparam int HT = 32;
  localparam int CW = 6;

  logic          tx_clock;
  logic          reset;
  logic          tx_strobe;
  logic [N-1:0]  chan_pkt_waiting, chan_burst, chan_skip, chan_tx_empty;
  logic [16*N-1:0] chan_tx_i, chan_tx_q;
  logic [N-1:0]  rd_pkt_waiting, rd_strobe, grant;
  logic [15:0]   tx_i, tx_q;
  logic          tx_empty, timeout_pulse;

  int n_cmp  = 0;
  int n_fail = 0;

  tx_chan_arbiter #(.NUM_CHAN(N), .HOLD_TIMEOUT(HT), .CW(CW)) dut (
    .tx_clock         (tx_clock),
    .reset            (reset),
    .tx_strobe        (tx_strobe),
    .chan_pkt_waiting (chan_pkt_waiting),
    .chan_burst       (chan_burst),
    .chan_skip        (chan_skip),
    .chan_tx_empty    (chan_tx_empty),
    .chan_tx_i        (chan_tx_i),
    .chan_tx_q        (chan_tx_q),
    .rd_pkt_waiting   (rd_pkt_waiting),
    .rd_strobe        (rd_strobe),
    .tx_i             (tx_i),
    .tx_q             (tx_q),
    .tx_empty         (tx_empty),
    .grant            (grant),
    .timeout_pulse    (timeout_pulse)
  );

  initial begin
    tx_clock = 1'b0;
    forever #5 tx_clock = ~tx_clock;
  end

  typedef struct {
    logic [1:0]  pw, burst, skip;
    logic        strobe;
    logic [1:0]  e_rds, e_rdpw;   // combinational, before the edge
    logic [1:0]  e_grant;         // registered, after the edge
    logic [15:0] e_i, e_q;
    logic        e_empty;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge tx_clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] pw, input logic [1:0] burst,
                       input logic [1:0] skip, input logic strobe);
    chan_pkt_waiting = pw;
    chan_burst       = burst;
    chan_skip        = skip;
    tx_strobe        = strobe;
  endtask

  initial begin
    // row: pw, burst, skip, strobe | rd_strobe, rd_pw | grant, i, q, empty
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 16'h0000, 16'h0000, 1'b1};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 2'b01, 16'hA0A0, 16'h0B0B, 1'b1};
    tbl[2]  = '{2'b10, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 16'hA0A0, 16'h0B0B, 1'b1};
    tbl[3]  = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 16'hA0A0, 16'h0B0B, 1'b1};
    tbl[4]  = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h0000, 1'b1};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b10, 16'h1234, 16'h5678, 1'b0};
    tbl[6]  = '{2'b11, 2'b01, 2'b01, 1'b1, 2'b10, 2'b10, 2'b10, 16'h1234, 16'h5678, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 2'b10, 1'b0, 2'b00, 2'b10, 2'b10, 16'h1234, 16'h5678, 1'b0};
    tbl[8]  = '{2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 16'h1234, 16'h5678, 1'b0};
    tbl[9]  = '{2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 16'h0000, 16'h0000, 1'b1};
    tbl[10] = '{2'b10, 2'b00, 2'b01, 1'b1, 2'b01, 2'b00, 2'b01, 16'hA0A0, 16'h0B0B, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 16'hA0A0, 16'h0B0B, 1'b1};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1};

    chan_tx_i     = {16'h1234, 16'hA0A0};
    chan_tx_q     = {16'h5678, 16'h0B0B};
    chan_tx_empty = 2'b01;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_grant", grant, 2'b00);
    chk("reset_tx_empty", tx_empty, 1'b1);
    chk("reset_tx_i", tx_i, 16'h0);
    chk("reset_timeout", timeout_pulse, 1'b0);
    $display("reset: grant=%b tx_empty=%b", grant, tx_empty);

    // Table: round-robin, skip handling, gating and data mux.
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].pw, tbl[r].burst, tbl[r].skip, tbl[r].strobe);
      #1;
      chk($sformatf("row%0d_rd_strobe", r), rd_strobe, tbl[r].e_rds);
      chk($sformatf("row%0d_rd_pkt_waiting", r), rd_pkt_waiting, tbl[r].e_rdpw);
      tick();
      chk($sformatf("row%0d_grant", r), grant, tbl[r].e_grant);
      chk($sformatf("row%0d_tx_i", r), tx_i, tbl[r].e_i);
      chk($sformatf("row%0d_tx_q", r), tx_q, tbl[r].e_q);
      chk($sformatf("row%0d_tx_empty", r), tx_empty, tbl[r].e_empty);
      chk($sformatf("row%0d_timeout", r), timeout_pulse, 1'b0);
      $display("row %0d: pw=%b skip=%b grant=%b tx_i=%h", r, tbl[r].pw, tbl[r].skip, grant, tx_i);
    end

    // Three-packet burst on ch1 with 20-cycle gaps, ch0 requesting throughout.
    drive(2'b10, 2'b00, 2'b00, 1'b0);
    tick();
    chk("burst_grant_start", grant, 2'b10);
    for (int p = 0; p < 3; p++) begin
      drive(2'b11, 2'b10, 2'b00, 1'b0);
      tick();
      chk($sformatf("burst%0d_active_grant", p), grant, 2'b10);
      drive(2'b01, (p < 2) ? 2'b10 : 2'b00, 2'b10, 1'b0);
      tick();
      chk($sformatf("burst%0d_skip_grant", p), grant, 2'b10);
      chan_skip = 2'b00;
      if (p < 2) begin
        for (int g = 0; g < 20; g++) begin
          tick();
          chk($sformatf("burst%0d_gap_grant", p), grant, 2'b10);
          chk($sformatf("burst%0d_gap_timeout", p), timeout_pulse, 1'b0);
        end
      end
      $display("burst packet %0d: grant=%b", p, grant);
    end
    tick();
    chk("burst_release_grant", grant, 2'b00);
    tick();
    chk("burst_next_owner_ch0", grant, 2'b01);
    drive(2'b00, 2'b00, 2'b01, 1'b0);
    tick();
    chan_skip = 2'b00;
    tick();
    chk("ch0_release_grant", grant, 2'b00);
    $display("burst done: grant=%b", grant);

    // Open burst with no further packet: forced release.
    drive(2'b10, 2'b00, 2'b00, 1'b0);
    tick();
    chk("to_grant", grant, 2'b10);
    drive(2'b00, 2'b10, 2'b10, 1'b0);
    tick();
    chan_skip = 2'b00;
    for (int k = 1; k <= HT; k++) begin
      tick();
      chk($sformatf("to_pulse_k%0d", k), timeout_pulse, (k == HT) ? 1'b1 : 1'b0);
    end
    chk("to_grant_at_pulse", grant, 2'b10);
    tick();
    chk("to_grant_after", grant, 2'b00);
    chk("to_pulse_cleared", timeout_pulse, 1'b0);
    $display("timeout: grant=%b", grant);

    // Request on the timeout cycle keeps the burst.
    drive(2'b10, 2'b00, 2'b00, 1'b0);
    tick();
    chk("race_grant", grant, 2'b10);
    drive(2'b00, 2'b10, 2'b10, 1'b0);
    tick();
    chan_skip = 2'b00;
    for (int k = 1; k < HT; k++) begin
      tick();
      chk("race_no_early_pulse", timeout_pulse, 1'b0);
    end
    chan_pkt_waiting = 2'b10;
    tick();
    chk("race_no_pulse", timeout_pulse, 1'b0);
    chk("race_grant_kept", grant, 2'b10);
    tick();
    chk("race_still_active", grant, 2'b10);
    chk("race_no_late_pulse", timeout_pulse, 1'b0);
    $display("race: grant=%b timeout=%b", grant, timeout_pulse);

    // Reset while in HOLD.
    drive(2'b00, 2'b10, 2'b10, 1'b1);
    tick();
    chan_skip = 2'b00;
    tick();
    tick();
    chk("pre_reset_tx_i", tx_i, 16'h1234);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_grant", grant, 2'b00);
    chk("rst_tx_empty", tx_empty, 1'b1);
    chk("rst_tx_i", tx_i, 16'h0);
    chk("rst_rd_strobe", rd_strobe, 2'b00);
    chan_pkt_waiting = 2'b10;
    tick();
    chk("post_rst_grant", grant, 2'b10);
    tick();
    chk("post_rst_tx_i", tx_i, 16'h1234);
    chk("post_rst_tx_empty", tx_empty, 1'b0);
    $display("reset mid-hold: grant=%b tx_i=%h", grant, tx_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
